// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues one imem request at a time, buffers returned words for decode.
// Optional IFETCH_SKID_BUF_EN: two-entry buffer so the next fetch can overlap a decode stall.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_Clk_1,
    input  logic        i_RstN_1,
    output logic        o_IMemReq_1,
    output logic [31:0] o_IMemAddr_32,
    input  logic        i_IMemAck_1,
    input  logic        i_IMemRValid_1,
    input  logic [31:0] i_IMemRData_32,
    input  logic        i_Redirect_1,
    input  logic [31:0] i_RedirectAddr_32,
    input  logic        i_WaitLoad_1,
    output logic        o_InstValid_1,
    output logic [31:0] o_Inst_32,
    output logic [31:0] o_InstPC_32,
    output logic [31:0] o_InstPCPlus4_32,
    input  logic        i_DecodeReady_1
);

`ifdef IFETCH_SKID_BUF_EN
    localparam int unsigned DEPTH = 2;
`else
    localparam int unsigned DEPTH = 1;
`endif
    localparam int unsigned CW  = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_REQ, ST_WAIT} state_t;

    state_t        r_State;
    state_t        w_StateNext;
    logic [31:0]   r_Pc;
    logic          r_Kill;
    logic          w_KillNext;
    logic [CW-1:0] r_Count;
    logic [31:0]   r_BufInst [DEPTH];
    logic [31:0]   r_BufPc   [DEPTH];

    logic          w_RspIn;
    logic          w_Push;
    logic          w_Pop;
    logic          w_InstValid;
    logic [CW-1:0] w_OccNext;
    logic [CW-1:0] w_WrIdx;
    logic          w_Go;

    assign w_RspIn     = (r_State == ST_WAIT) && i_IMemRValid_1;
    assign w_Push      = w_RspIn && !r_Kill;
    assign w_InstValid = (r_Count != '0);
    assign w_Pop       = w_InstValid && i_DecodeReady_1;
    assign w_WrIdx     = r_Count - CW'(w_Pop);

    // Occupancy as it will be next cycle; issuing against it keeps room for the response.
    always_comb begin
        w_OccNext = r_Count + CW'(w_Push) - CW'(w_Pop);
        if (i_Redirect_1) begin
            w_OccNext = '0;
        end
    end

    assign w_Go = (w_OccNext < CW'(DEPTH)) && !i_WaitLoad_1;

    always_comb begin
        w_StateNext = r_State;
        case (r_State)
            ST_IDLE:  w_StateNext = ST_CHECK;
            ST_CHECK: if (w_Go) w_StateNext = ST_REQ;
            ST_REQ:   if (i_IMemAck_1) w_StateNext = ST_WAIT;
            ST_WAIT:  if (i_IMemRValid_1) w_StateNext = w_Go ? ST_REQ : ST_CHECK;
            default:  w_StateNext = ST_IDLE;
        endcase
    end

    // Kill marks a request still in flight past a redirect; a response landing this cycle closes it instead.
    always_comb begin
        w_KillNext = r_Kill;
        if (w_RspIn) begin
            w_KillNext = 1'b0;
        end
        if (i_Redirect_1 && (((r_State == ST_WAIT) && !i_IMemRValid_1) ||
                             ((r_State == ST_REQ) && i_IMemAck_1))) begin
            w_KillNext = 1'b1;
        end
    end

    always_ff @(posedge i_Clk_1 or negedge i_RstN_1) begin
        if (!i_RstN_1) begin
            r_State <= ST_IDLE;
            r_Pc    <= RESET_PC;
            r_Kill  <= 1'b0;
            r_Count <= '0;
        end else begin
            r_State <= w_StateNext;
            r_Kill  <= w_KillNext;
            r_Count <= w_OccNext;
            if (i_Redirect_1) begin
                r_Pc <= {i_RedirectAddr_32[31:2], 2'b00};
            end else if (w_Push) begin
                r_Pc <= r_Pc + 32'd4;
            end
        end
    end

    always_ff @(posedge i_Clk_1 or negedge i_RstN_1) begin
        if (!i_RstN_1) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_BufInst[i] <= '0;
                r_BufPc[i]   <= '0;
            end
        end else if (!i_Redirect_1) begin
            for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                if (w_Pop) begin
                    r_BufInst[i] <= r_BufInst[i+1];
                    r_BufPc[i]   <= r_BufPc[i+1];
                end
            end
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (w_Push && (i == 32'(w_WrIdx))) begin
                    r_BufInst[i] <= i_IMemRData_32;
                    r_BufPc[i]   <= r_Pc;
                end
            end
        end
    end

    assign o_IMemReq_1      = (r_State == ST_REQ);
    assign o_IMemAddr_32    = r_Pc;
    assign o_InstValid_1    = w_InstValid;
    assign o_Inst_32        = w_InstValid ? r_BufInst[0] : NOP;
    assign o_InstPC_32      = w_InstValid ? r_BufPc[0] : '0;
    assign o_InstPCPlus4_32 = o_InstPC_32 + 32'd4;

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Owns the architectural PC register and sequences instruction fetch for the RV32I pipeline front end. Issues one request at a time to instruction memory over a req/ack/rvalid handshake, and applies redirects from branch/jump resolution and load-wait stalls. Buffers returned instructions toward decode over a valid/ready interface. It sits between the PC-selection logic and the IF/DE stage register, replacing the free-running PC update.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- i_Clk_1  in  1  clock; all state updates on the rising edge.
- i_RstN_1  in  1  reset; asynchronous, active-low.
- o_IMemReq_1  out  1  fetch request valid.
- o_IMemAddr_32  out  32  fetch address (word aligned).
- i_IMemAck_1  in  1  memory accepts the request this cycle.
- i_IMemRValid_1  in  1  read data valid.
- i_IMemRData_32  in  32  instruction word.
- i_Redirect_1  in  1  one-cycle pulse: taken branch/jump resolved.
- i_RedirectAddr_32  in  32  redirect target.
- i_WaitLoad_1  in  1  load-wait stall; no new request is issued while high.
- o_InstValid_1  out  1  buffer head valid toward decode.
- o_Inst_32  out  32  head instruction; 32'h0000_0013 (NOP) when empty.
- o_InstPC_32  out  32  PC of head instruction.
- o_InstPCPlus4_32  out  32  head PC + 4.
- i_DecodeReady_1  in  1  decode consumes head when high with o_InstValid_1.

## Operation
- FSM states:
  - IDLE (entered on reset, lasts exactly one cycle) -> CHECK.
  - CHECK: go to REQ when slot-free and !i_WaitLoad_1; otherwise stay.
  - REQ: o_IMemReq_1=1, o_IMemAddr_32=PC. Go to WAIT on i_IMemAck_1. Address and req are held stable until ack.
  - WAIT: await i_IMemRValid_1. On rvalid, go to CHECK (or straight to REQ when the CHECK condition already holds, evaluated with post-pop occupancy).
- slot-free: buffer occupancy + outstanding request < DEPTH. An arriving response therefore always has room.
- On accepted rvalid (not killed): push {data, PC_of_request}; PC <= PC_of_request + 4, using 32-bit wrap-around arithmetic.
- Redirect (acts regardless of i_WaitLoad_1 and of state):
  - PC <= i_RedirectAddr_32.
  - Buffer flushed, including any same-cycle push; any same-cycle pop is ignored.
  - If a request is outstanding (WAIT, or REQ with ack that cycle), set kill. The next rvalid is discarded and clears kill.
  - If in REQ without ack, the address switches to the new PC the next cycle. Req stays asserted.
- Buffer: FIFO, pop when o_InstValid_1 & i_DecodeReady_1. Push and pop in the same cycle are both allowed.
- i_WaitLoad_1 never cancels a request already asserted; it only blocks CHECK->REQ.

## Timing
- Reset values: o_IMemReq_1=0, o_IMemAddr_32=RESET_PC, o_InstValid_1=0, o_Inst_32=32'h0000_0013, o_InstPC_32=0, o_InstPCPlus4_32=4, kill=0, buffer empty.
- First o_IMemReq_1 is asserted in the 2nd cycle after reset release.
- Ack may occur in the same cycle as req. Rvalid comes at the earliest 1 cycle after ack.
- Pushed instruction is visible on o_InstValid_1 the cycle after rvalid.
- Best-case throughput: 1 instruction per 2 cycles.
- Reset assertion mid-transaction clears everything immediately. A late rvalid after reset release, with no request outstanding, is ignored.

## Configuration
- IFETCH_SKID_BUF_EN defined: DEPTH=2. The next request may issue while one instruction waits for decode.
- IFETCH_SKID_BUF_EN undefined: DEPTH=1. A single output register, so no request is issued until the head is popped.

## Test plan
- Reset, memory acks same cycle with rvalid 1 cycle later, decode always ready -> addresses 0,4,8,12 fetched; o_InstPC_32 tracks them; req first high at cycle 2.
- Decode ready held low -> with the macro, exactly 2 instructions buffered then req stays low; without it, 1 instruction.
- Redirect to 32'h0000_0100 while in WAIT for 0x8 -> 0x8 data discarded, buffer flushed, next req addr 0x100, next o_InstPC_32=0x100.
- i_WaitLoad_1 high for 3 cycles in CHECK -> no req for 3 cycles; req resumes with unchanged PC. Redirect during the stall still updates PC.
- RESET_PC=32'hFFFF_FFFC -> fetch 0xFFFF_FFFC then 0x0000_0000 (wrap).
- Reset asserted in WAIT with rvalid pulsed after release -> outputs at reset values, no instruction pushed, first req at RESET_PC.
